adc_fault_monitor: RTL and testbench

Multi-channel over-/under-voltage monitor for a time-multiplexed ADC stream, generalising the single-channel threshold flag block. Each tagged sample updates only its own channel's state:
- per-channel programmable thresholds with hysteresis
- debounce qualification over consecutive samples
- sticky fault capture with masked clear
Outputs feed the fault FSM and status registers.

---
 rtl/adc_mon_pkg.sv | 44 ++++
 rtl/adc_ch_qual.sv | 76 +++++++
 rtl/adc_fault_monitor.sv | 97 +++++++++
 tb/tb_adc_fault_monitor.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_mon_pkg.sv
// adc_mon_pkg: shared types, constants and saturating helpers for the
// multi-channel ADC fault monitor (adc_fault_monitor / adc_ch_qual).
package adc_mon_pkg;

   localparam int MAX_NCH       = 16;    // supported channel-count limit
   localparam int DEF_OV_THRESH = 3500;  // default over-voltage threshold
   localparam int DEF_UV_THRESH = 2500;  // default under-voltage threshold
   localparam int DEB_CNT_W     = 8;     // holds DEB up to 255

   // Per-channel status bundle returned by one channel qualifier
   typedef struct packed {
      logic ov_flag;
      logic uv_flag;
      logic ov_sticky;
      logic uv_sticky;
   } ch_status_t;

   // a - b, clamped at 0
   function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
      return (a > b) ? (a - b) : 32'd0;
   endfunction

   // a + b, clamped at 2^w - 1 (one spare bit keeps the carry visible)
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                           input int unsigned w);
      logic [32:0] s;
      logic [32:0] max_v;
      s     = {1'b0, a} + {1'b0, b};
      max_v = (33'd1 << w) - 33'd1;
      return (s > max_v) ? max_v[31:0] : s[31:0];
   endfunction

   // One debounce step: returns {flag_next, cnt_next}.
   // Agreement clears the run; the DEB-th disagreement adopts the candidate.
   // cnt never exceeds last, so it cannot wrap.
   function automatic logic [DEB_CNT_W:0] deb_step(input logic cand, input logic flag,
                                                   input logic [DEB_CNT_W-1:0] cnt,
                                                   input logic [DEB_CNT_W-1:0] last);
      if (cand == flag) return {flag, {DEB_CNT_W{1'b0}}};
      if (cnt >= last)  return {cand, {DEB_CNT_W{1'b0}}};
      return {flag, cnt + 1'b1};
   endfunction

endpackage

// File: rtl/adc_ch_qual.sv
// adc_ch_qual: one channel of the fault monitor -- raw OV/UV hysteresis,
// debounce of both flags and sticky capture.
// Ports: clk, rst_n (async low); acc = accepted sample for this channel;
// sample, ov_th, uv_th (WIDTH); clr = sticky clear; st = status bundle.
module adc_ch_qual
   import adc_mon_pkg::*;
#(
   parameter int WIDTH = 12,
   parameter int HYST  = 20,
   parameter int DEB   = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             acc,
   input  logic [WIDTH-1:0] sample,
   input  logic [WIDTH-1:0] ov_th,
   input  logic [WIDTH-1:0] uv_th,
   input  logic             clr,
   output ch_status_t       st
);

   localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEB_CNT_W'(DEB - 1);

   logic [WIDTH-1:0]     ov_lo, uv_hi;
   logic                 ov_raw, uv_raw, ov_cand, uv_cand;
   logic                 ov_flag, uv_flag, ov_stk, uv_stk;
   logic                 ov_flag_nxt, uv_flag_nxt;
   logic [DEB_CNT_W-1:0] ov_cnt, uv_cnt, ov_cnt_nxt, uv_cnt_nxt;

   // Release points, saturated so low OV / high UV thresholds cannot wrap
   assign ov_lo = WIDTH'(sat_sub(32'(ov_th), 32'(HYST)));
   assign uv_hi = WIDTH'(sat_add(32'(uv_th), 32'(HYST), WIDTH));

   // Candidate raw values; set has priority if both edges coincide
   always_comb begin
      ov_cand = ov_raw;
      if (sample >= ov_th)      ov_cand = 1'b1;
      else if (sample <= ov_lo) ov_cand = 1'b0;
      uv_cand = uv_raw;
      if (sample <= uv_th)      uv_cand = 1'b1;
      else if (sample >= uv_hi) uv_cand = 1'b0;
   end

   always_comb begin
      {ov_flag_nxt, ov_cnt_nxt} = deb_step(ov_cand, ov_flag, ov_cnt, DEB_LAST);
      {uv_flag_nxt, uv_cnt_nxt} = deb_step(uv_cand, uv_flag, uv_cnt, DEB_LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ov_raw  <= 1'b0;
         uv_raw  <= 1'b0;
         ov_flag <= 1'b0;
         uv_flag <= 1'b0;
         ov_cnt  <= '0;
         uv_cnt  <= '0;
         ov_stk  <= 1'b0;
         uv_stk  <= 1'b0;
      end else begin
         if (acc) begin
            ov_raw  <= ov_cand;
            uv_raw  <= uv_cand;
            ov_flag <= ov_flag_nxt;
            uv_flag <= uv_flag_nxt;
            ov_cnt  <= ov_cnt_nxt;
            uv_cnt  <= uv_cnt_nxt;
         end
         // Set from the current flag wins over a same-cycle clear
         ov_stk <= (ov_stk & ~clr) | ov_flag;
         uv_stk <= (uv_stk & ~clr) | uv_flag;
      end
   end

   assign st = '{ov_flag: ov_flag, uv_flag: uv_flag, ov_sticky: ov_stk, uv_sticky: uv_stk};

endmodule

// File: rtl/adc_fault_monitor.sv
// adc_fault_monitor: multi-channel OV/UV monitor for a tagged, time-multiplexed
// ADC stream. Decodes the channel tag, unpacks thresholds, instantiates one
// adc_ch_qual per channel and registers the combined fault_any.
// Ports: clk, rst_n (async low); adc_valid/adc_ch/adc_sample input stream;
// ov_thresh/uv_thresh packed per channel; clr_mask sticky clear;
// ov_flag/uv_flag/ov_sticky/uv_sticky per channel; fault_any; stale.
// Optional: define ADC_FAULT_MON_STALE_EN for the per-channel starvation
// watchdog (STALE_CYCLES); otherwise stale is tied low.
module adc_fault_monitor
   import adc_mon_pkg::*;
#(
   parameter int WIDTH        = 12,
   parameter int NCH          = 4,
   parameter int CH_W         = (NCH > 1) ? $clog2(NCH) : 1,
   parameter int HYST         = 20,
   parameter int DEB          = 3,
   parameter int STALE_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 adc_valid,
   input  logic [CH_W-1:0]      adc_ch,
   input  logic [WIDTH-1:0]     adc_sample,
   input  logic [NCH*WIDTH-1:0] ov_thresh,
   input  logic [NCH*WIDTH-1:0] uv_thresh,
   input  logic [NCH-1:0]       clr_mask,
   output logic [NCH-1:0]       ov_flag,
   output logic [NCH-1:0]       uv_flag,
   output logic [NCH-1:0]       ov_sticky,
   output logic [NCH-1:0]       uv_sticky,
   output logic                 fault_any,
   output logic [NCH-1:0]       stale
);

   logic [NCH-1:0] acc;
   ch_status_t     st [NCH];

   // Tags >= NCH match no channel and are dropped
   always_comb begin
      acc = '0;
      for (int i = 0; i < NCH; i++)
         acc[i] = adc_valid && (adc_ch == CH_W'(i));
   end

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      adc_ch_qual #(
         .WIDTH (WIDTH),
         .HYST  (HYST),
         .DEB   (DEB)
      ) u_qual (
         .clk    (clk),
         .rst_n  (rst_n),
         .acc    (acc[g]),
         .sample (adc_sample),
         .ov_th  (ov_thresh[g*WIDTH +: WIDTH]),
         .uv_th  (uv_thresh[g*WIDTH +: WIDTH]),
         .clr    (clr_mask[g]),
         .st     (st[g])
      );
      assign ov_flag[g]   = st[g].ov_flag;
      assign uv_flag[g]   = st[g].uv_flag;
      assign ov_sticky[g] = st[g].ov_sticky;
      assign uv_sticky[g] = st[g].uv_sticky;
   end

`ifdef ADC_FAULT_MON_STALE_EN
   localparam int STALE_W = $clog2(STALE_CYCLES + 1);
   localparam logic [STALE_W-1:0] STALE_LIM = STALE_W'(STALE_CYCLES);

   logic [NCH-1:0][STALE_W-1:0] stale_cnt;

   // Counts clocks since the channel's last accepted sample, parks at the limit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stale_cnt <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (acc[i])                       stale_cnt[i] <= '0;
            else if (stale_cnt[i] != STALE_LIM) stale_cnt[i] <= stale_cnt[i] + 1'b1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NCH; i++)
         stale[i] = (stale_cnt[i] == STALE_LIM);
   end
`else
   assign stale = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fault_any <= 1'b0;
      else        fault_any <= |{ov_flag, uv_flag, ov_sticky, uv_sticky, stale};
   end

endmodule

// File: tb/tb_adc_fault_monitor.sv
module tb_adc_fault_monitor;
   import adc_mon_pkg::*;

   localparam int WIDTH = 12;
   localparam int NCH   = 4;
   localparam int CH_W  = 3;    // wide enough to present out-of-range tags
   localparam int HYST  = 20;
   localparam int DEB   = 3;
   localparam int ST    = 16;
   localparam int MAXV  = (1 << WIDTH) - 1;

   logic                 clk, rst_n, adc_valid, fault_any;
   logic [CH_W-1:0]      adc_ch;
   logic [WIDTH-1:0]     adc_sample;
   logic [NCH*WIDTH-1:0] ov_thresh, uv_thresh;
   logic [NCH-1:0]       clr_mask, ov_flag, uv_flag, ov_sticky, uv_sticky, stale;

   adc_fault_monitor #(
      .WIDTH(WIDTH), .NCH(NCH), .CH_W(CH_W), .HYST(HYST), .DEB(DEB), .STALE_CYCLES(ST)
   ) dut (
      .clk(clk), .rst_n(rst_n), .adc_valid(adc_valid), .adc_ch(adc_ch),
      .adc_sample(adc_sample), .ov_thresh(ov_thresh), .uv_thresh(uv_thresh),
      .clr_mask(clr_mask), .ov_flag(ov_flag), .uv_flag(uv_flag),
      .ov_sticky(ov_sticky), .uv_sticky(uv_sticky), .fault_any(fault_any),
      .stale(stale)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: per-channel state as plain ints/bits
   int ov_th [NCH];
   int uv_th [NCH];
   bit m_ovr [NCH], m_uvr [NCH], m_ovf [NCH], m_uvf [NCH], m_ovs [NCH], m_uvs [NCH];
   int m_ovc [NCH], m_uvc [NCH], m_scnt [NCH];
   bit m_fault;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_ovr[i] = 0; m_uvr[i] = 0; m_ovf[i] = 0; m_uvf[i] = 0;
         m_ovs[i] = 0; m_uvs[i] = 0; m_ovc[i] = 0; m_uvc[i] = 0; m_scnt[i] = 0;
      end
      m_fault = 0;
   endtask

   function automatic bit exp_stale(int i);
`ifdef ADC_FAULT_MON_STALE_EN
      return m_scnt[i] >= ST;
`else
      return 1'b0;
`endif
   endfunction

   // Advance the model by one clock edge given this cycle's inputs
   task automatic model_step(input bit v, input int ch, input int s, input logic [NCH-1:0] clr);
      bit f;
      bit cand;
      int lo, hi;
      f = 0;
      for (int i = 0; i < NCH; i++)
         f |= m_ovf[i] | m_uvf[i] | m_ovs[i] | m_uvs[i] | exp_stale(i);
      for (int i = 0; i < NCH; i++) begin
         m_ovs[i] = (m_ovs[i] && !clr[i]) || m_ovf[i];
         m_uvs[i] = (m_uvs[i] && !clr[i]) || m_uvf[i];
      end
      if (v && ch < NCH) begin
         lo = (ov_th[ch] > HYST) ? ov_th[ch] - HYST : 0;
         hi = (uv_th[ch] + HYST > MAXV) ? MAXV : uv_th[ch] + HYST;
         cand = (s >= ov_th[ch]) ? 1'b1 : (s <= lo) ? 1'b0 : m_ovr[ch];
         m_ovr[ch] = cand;
         if (cand != m_ovf[ch]) begin
            m_ovc[ch]++;
            if (m_ovc[ch] == DEB) begin m_ovf[ch] = cand; m_ovc[ch] = 0; end
         end else m_ovc[ch] = 0;
         cand = (s <= uv_th[ch]) ? 1'b1 : (s >= hi) ? 1'b0 : m_uvr[ch];
         m_uvr[ch] = cand;
         if (cand != m_uvf[ch]) begin
            m_uvc[ch]++;
            if (m_uvc[ch] == DEB) begin m_uvf[ch] = cand; m_uvc[ch] = 0; end
         end else m_uvc[ch] = 0;
      end
      for (int i = 0; i < NCH; i++)
         if (v && ch == i) m_scnt[i] = 0;
         else if (m_scnt[i] < ST) m_scnt[i]++;
      m_fault = f;
   endtask

   task automatic check_all(input string tag);
      logic [NCH-1:0] e_ovf, e_uvf, e_ovs, e_uvs, e_st;
      for (int i = 0; i < NCH; i++) begin
         e_ovf[i] = m_ovf[i]; e_uvf[i] = m_uvf[i];
         e_ovs[i] = m_ovs[i]; e_uvs[i] = m_uvs[i]; e_st[i] = exp_stale(i);
      end
      chk({tag, " ov_flag"},   32'(ov_flag),   32'(e_ovf));
      chk({tag, " uv_flag"},   32'(uv_flag),   32'(e_uvf));
      chk({tag, " ov_sticky"}, 32'(ov_sticky), 32'(e_ovs));
      chk({tag, " uv_sticky"}, 32'(uv_sticky), 32'(e_uvs));
      chk({tag, " fault_any"}, 32'(fault_any), 32'(m_fault));
      chk({tag, " stale"},     32'(stale),     32'(e_st));
   endtask

   task automatic drive_th();
      for (int i = 0; i < NCH; i++) begin
         ov_thresh[i*WIDTH +: WIDTH] = WIDTH'(ov_th[i]);
         uv_thresh[i*WIDTH +: WIDTH] = WIDTH'(uv_th[i]);
      end
   endtask

   // One clock: present inputs, take the edge, compare #1 later
   task automatic cyc(input string tag, input bit v, input int ch, input int s,
                      input logic [NCH-1:0] clr);
      adc_valid  = v;
      adc_ch     = CH_W'(ch);
      adc_sample = WIDTH'(s);
      clr_mask   = clr;
      drive_th();
      @(posedge clk);
      #1;
      model_step(v, ch, s, clr);
      check_all(tag);
      adc_valid = 1'b0;
      clr_mask  = '0;
   endtask

   task automatic samp(input string tag, input int ch, input int s, input int n);
      for (int k = 0; k < n; k++) cyc(tag, 1'b1, ch, s, '0);
   endtask

   task automatic set_default_th();
      for (int i = 0; i < NCH; i++) begin ov_th[i] = DEF_OV_THRESH; uv_th[i] = DEF_UV_THRESH; end
   endtask

   initial begin
      logic [NCH-1:0] snap;
      rst_n = 1'b0; adc_valid = 1'b0; adc_ch = '0; adc_sample = '0; clr_mask = '0;
      set_default_th();
      drive_th();
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      check_all("reset");

      // 1. Async reset mid-stream, then counters proven cleared
      samp("t1", 1, 3600, 3);
      chk("t1 ov1 set", 32'(ov_flag[1]), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t1 async ov_flag", 32'(ov_flag), 32'd0);
      chk("t1 async sticky", 32'({ov_sticky, uv_sticky}), 32'd0);
      chk("t1 async fault", 32'(fault_any), 32'd0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      samp("t1 post", 1, 3600, 2);
      chk("t1 no flag after 2", 32'(ov_flag[1]), 32'd0);

      // 2. Debounce with an interrupted run and interleaved ch1
      samp("t2", 0, 3600, 1); samp("t2", 1, 3000, 1);
      samp("t2", 0, 3600, 1); samp("t2", 1, 3000, 1);
      samp("t2", 0, 3000, 1); samp("t2", 1, 3000, 1);
      samp("t2", 0, 3600, 2); samp("t2", 1, 3000, 1);
      chk("t2 before 6th", 32'(ov_flag[0]), 32'd0);
      samp("t2", 0, 3600, 1);
      chk("t2 on 6th", 32'(ov_flag[0]), 32'd1);

      // 3. Hysteresis on ch2
      samp("t3", 2, 3600, 3);
      samp("t3", 2, 3490, 3);
      chk("t3 ov hold", 32'(ov_flag[2]), 32'd1);
      samp("t3", 2, 3480, 2);
      chk("t3 ov 2 of 3", 32'(ov_flag[2]), 32'd1);
      samp("t3", 2, 3480, 1);
      chk("t3 ov clear", 32'(ov_flag[2]), 32'd0);
      samp("t3", 2, 2400, 3);
      chk("t3 uv set", 32'(uv_flag[2]), 32'd1);
      samp("t3", 2, 2510, 3);
      chk("t3 uv hold", 32'(uv_flag[2]), 32'd1);
      samp("t3", 2, 2520, 3);
      chk("t3 uv clear", 32'(uv_flag[2]), 32'd0);

      // 4. Saturated release points on ch3
      ov_th[3] = 10; uv_th[3] = 4090;
      samp("t4", 3, 4095, 3);
      chk("t4 ov at 4095", 32'(ov_flag[3]), 32'd1);
      chk("t4 uv at 4095", 32'(uv_flag[3]), 32'd0);
      samp("t4", 3, 0, 3);
      chk("t4 ov at 0", 32'(ov_flag[3]), 32'd0);
      chk("t4 uv at 0", 32'(uv_flag[3]), 32'd1);
      samp("t4", 3, 4095, 3);
      chk("t4 uv release", 32'(uv_flag[3]), 32'd0);
      set_default_th();

      // 5. Sticky clear vs. set
      samp("t5", 0, 3000, 3);
      chk("t5 flag dropped", 32'(ov_flag[0]), 32'd0);
      chk("t5 sticky held", 32'(ov_sticky[0]), 32'd1);
      cyc("t5 clr", 1'b0, 0, 0, 4'b0001);
      chk("t5 sticky cleared", 32'(ov_sticky[0]), 32'd0);
      samp("t5", 0, 3600, 3);
      cyc("t5 clr vs set", 1'b0, 0, 0, 4'b0001);
      chk("t5 set wins", 32'(ov_sticky[0]), 32'd1);
      samp("t5", 0, 3000, 3);
      cyc("t5 clr2", 1'b0, 0, 0, 4'b0001);
      chk("t5 sticky cleared2", 32'(ov_sticky[0]), 32'd0);

      // 6. Out-of-range tag and starvation watchdog
      snap = ov_flag;
      for (int k = 0; k < 4; k++) cyc("t6 bad ch", 1'b1, 5, (k[0]) ? 0 : 4095, '0);
      chk("t6 ignored", 32'(ov_flag), 32'(snap));
      samp("t6", 1, 3000, 1);
      for (int k = 0; k < ST - 1; k++) cyc("t6 idle", 1'b0, 0, 0, '0);
      chk("t6 not yet stale", 32'(stale[1]), 32'd0);
      cyc("t6 idle", 1'b0, 0, 0, '0);
`ifdef ADC_FAULT_MON_STALE_EN
      chk("t6 stale", 32'(stale[1]), 32'd1);
`else
      chk("t6 stale off", 32'(stale[1]), 32'd0);
`endif
      samp("t6", 1, 3000, 1);
      chk("t6 stale cleared", 32'(stale[1]), 32'd0);

      // Randomised traffic against the model
      for (int n = 0; n < 600; n++) begin
         int c, s, base;
         logic [NCH-1:0] clr;
         if (n % 150 == 0)
            for (int i = 0; i < NCH; i++) begin
               ov_th[i] = int'($urandom_range(3600, 3000));
               uv_th[i] = int'($urandom_range(2800, 2300));
            end
         c = int'($urandom_range(5, 0));
         base = ($urandom_range(1, 0) != 0) ? ov_th[c % NCH] : uv_th[c % NCH];
         s = base + int'($urandom_range(60, 0)) - 30;
         if ($urandom_range(19, 0) == 0) s = ($urandom_range(1, 0) != 0) ? MAXV : 0;
         if (s < 0) s = 0;
         if (s > MAXV) s = MAXV;
         clr = ($urandom_range(9, 0) == 0) ? NCH'($urandom) : '0;
         cyc("rand", ($urandom_range(4, 0) != 0), c, s, clr);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
